// File: rtl/filt_pkg.sv
// Shared types for the scanned glitch filter.
//   fstate_t : 2-bit per-channel filter state (Z0/Z1 low side, E0/E1 high side)
//   idx_w()  : width of a channel index for a given channel count
package filt_pkg;

  typedef enum logic [1:0] {
    Z0 = 2'd0,  // stable low
    Z1 = 2'd1,  // candidate high
    E0 = 2'd2,  // stable high
    E1 = 2'd3   // candidate low
  } fstate_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filt_step.sv
// One filter step for a single channel: pure combinational next-state
// function shared by all channels of filt_scan.
//   st/cnt/y  : stored state, counter, filtered level of the serviced channel
//   i         : raw input of that channel, sampled this cycle
//   st_nx/cnt_nx/y_nx : values written back to the banks
//   evt       : a transition is accepted by this step
module filt_step
  import filt_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int THRESH = 9
) (
  input  fstate_t          st,
  input  logic [CNT_W-1:0] cnt,
  input  logic             y,
  input  logic             i,
  output fstate_t          st_nx,
  output logic [CNT_W-1:0] cnt_nx,
  output logic             y_nx,
  output logic             evt
);

  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

  logic             over;
  logic [CNT_W-1:0] cnt_inc;

  assign over    = (cnt > TH);
  // saturating increment; cannot actually saturate when THRESH+1 fits
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    y_nx   = y;
    evt    = 1'b0;
    case (st)
      Z0: if (i) begin
        st_nx  = Z1;
        cnt_nx = '0;
      end
      Z1: begin
        // threshold wins over the current sample
        if (over) begin
          st_nx  = E0;
          cnt_nx = '0;
          y_nx   = 1'b1;
          evt    = 1'b1;
        end else if (!i) begin
          st_nx  = Z0;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      E0: if (!i) begin
        st_nx  = E1;
        cnt_nx = '0;
      end
      E1: begin
        if (over) begin
          st_nx  = Z0;
          cnt_nx = '0;
          y_nx   = 1'b0;
          evt    = 1'b1;
        end else if (i) begin
          st_nx  = E0;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        st_nx  = Z0;
        cnt_nx = '0;
      end
    endcase
  end

endmodule

// File: rtl/filt_scan.sv
// Round-robin scanned glitch filter: one filt_step shared across N channels.
// Per-channel state, counter and filtered level live in register banks; the
// channel at ptr is serviced each enabled cycle and ptr advances (wrapping).
// Optional macro FILT_SCAN_SYNC_EN adds a 2-flop synchronizer on every input
// bit ahead of sampling (2 cycles extra latency).
//   clk, rst_n : clock, async active-low reset
//   en         : scan enable; 0 freezes pointer and channel state
//   i          : raw inputs, one bit per channel
//   y          : filtered levels
//   evt_vld/evt_ch/evt_val : one-cycle event on accepted transition
//   ptr        : channel serviced this cycle
module filt_scan
  import filt_pkg::*;
#(
  parameter int N      = 4,
  parameter int CNT_W  = 4,
  parameter int THRESH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         i,
  output logic [N-1:0]         y,
  output logic                 evt_vld,
  output logic [idx_w(N)-1:0]  evt_ch,
  output logic                 evt_val,
  output logic [idx_w(N)-1:0]  ptr
);

  localparam int IW = idx_w(N);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("filt_scan: N must be in 2..16");
    end
    if (THRESH + 1 > (2 ** CNT_W) - 1) begin : g_bad_thresh
      $error("filt_scan: THRESH+1 must fit below counter saturation");
    end
  endgenerate

  // ---------------- input conditioning ----------------
  logic [N-1:0] i_s;

`ifdef FILT_SCAN_SYNC_EN
  logic [N-1:0] sync1, sync2;

  // free-running: keeps tracking pins even while the scan is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i;
      sync2 <= sync1;
    end
  end

  assign i_s = sync2;
`else
  assign i_s = i;
`endif

  // ---------------- channel banks ----------------
  fstate_t [N-1:0]            st_q;
  logic    [N-1:0][CNT_W-1:0] cnt_q;

  fstate_t          st_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             y_nx;
  logic             step_evt;
  logic             last;

  filt_step #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_step (
    .st     (st_q[ptr]),
    .cnt    (cnt_q[ptr]),
    .y      (y[ptr]),
    .i      (i_s[ptr]),
    .st_nx  (st_nx),
    .cnt_nx (cnt_nx),
    .y_nx   (y_nx),
    .evt    (step_evt)
  );

  assign last = (ptr == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) st_q[k] <= Z0;
      cnt_q   <= '0;
      y       <= '0;
      ptr     <= '0;
      evt_vld <= 1'b0;
      evt_ch  <= '0;
      evt_val <= 1'b0;
    end else begin
      evt_vld <= 1'b0;
      if (en) begin
        st_q[ptr]  <= st_nx;
        cnt_q[ptr] <= cnt_nx;
        y[ptr]     <= y_nx;
        ptr        <= last ? '0 : ptr + IW'(1);
        // channel/value hold their last event between events
        if (step_evt) begin
          evt_vld <= 1'b1;
          evt_ch  <= ptr;
          evt_val <= y_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_filt_scan.sv
// Self-checking bench for filt_scan. The reference model tracks, per channel,
// the accepted level and the length of the current run of services that saw
// the opposite level; a transition is accepted on the service after the run
// reaches THRESH+2.
module tb_filt_scan;

  localparam int N      = 4;
  localparam int CNT_W  = 4;
  localparam int THRESH = 9;
  localparam int IW     = 2;

`ifdef FILT_SCAN_SYNC_EN
  localparam int SYNC_ADD = 4;
  localparam int ALL4_PRE = 6;
  localparam bit SYNC     = 1'b1;
`else
  localparam int SYNC_ADD = 0;
  localparam int ALL4_PRE = 8;
  localparam bit SYNC     = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  i;
  logic [N-1:0]  y;
  logic          evt_vld;
  logic [IW-1:0] evt_ch;
  logic          evt_val;
  logic [IW-1:0] ptr;

  filt_scan #(.N(N), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i       (i),
    .y       (y),
    .evt_vld (evt_vld),
    .evt_ch  (evt_ch),
    .evt_val (evt_val),
    .ptr     (ptr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_evt = 0;
  int cyc_no = 0;

  // reference model state
  logic [N-1:0] m_lvl;
  int           m_run [N];
  int           m_ptr;
  logic         m_vld;
  int           m_ch;
  logic         m_val;
  logic [N-1:0] m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;
    m_ptr = 0;
    m_vld = 1'b0;
    m_ch  = 0;
    m_val = 1'b0;
    m_s1  = '0;
    m_s2  = '0;
  endtask

  task automatic model_step(input logic e, input logic [N-1:0] iv);
    logic [N-1:0] samp;
    samp  = SYNC ? m_s2 : iv;
    m_s2  = m_s1;
    m_s1  = iv;
    m_vld = 1'b0;
    if (e) begin
      if (m_run[m_ptr] == THRESH + 2) begin
        m_lvl[m_ptr] = ~m_lvl[m_ptr];
        m_run[m_ptr] = 0;
        m_vld = 1'b1;
        m_ch  = m_ptr;
        m_val = m_lvl[m_ptr];
      end else if (samp[m_ptr] != m_lvl[m_ptr]) begin
        m_run[m_ptr]++;
      end else begin
        m_run[m_ptr] = 0;
      end
      m_ptr = (m_ptr + 1) % N;
    end
  endtask

  // entered and left at a falling edge
  task automatic cyc1(input logic e, input logic [N-1:0] iv);
    en = e;
    i  = iv;
    @(posedge clk);
    model_step(e, iv);
    #1;
    chk("y",       32'(y),       32'(m_lvl));
    chk("evt_vld", 32'(evt_vld), 32'(m_vld));
    chk("evt_ch",  32'(evt_ch),  32'(m_ch));
    chk("evt_val", 32'(evt_val), 32'(m_val));
    chk("ptr",     32'(ptr),     32'(m_ptr));
    if (evt_vld) n_evt++;
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y",   32'(y),       32'd0);
    chk("rst_ptr", 32'(ptr),     32'd0);
    chk("rst_vld", 32'(evt_vld), 32'd0);
    chk("rst_ch",  32'(evt_ch),  32'd0);
    chk("rst_val", 32'(evt_val), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_y(input int k, input logic [N-1:0] iv, inout int n);
    while (!y[k] && n < 400) begin
      cyc1(1'b1, iv);
      n++;
    end
  endtask

  initial begin
    int n;
    int ev_ch [$];
    int ev_cy [$];
    logic [N-1:0] cur, drv;

    rst_n = 1'b1;
    en    = 1'b0;
    i     = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // idle scan: pointer cycles, nothing accepted
    n_evt = 0;
    for (int c = 0; c < 100; c++) cyc1(1'b1, '0);
    chk("idle_evts", 32'(n_evt), 32'd0);

    // acceptance latency on ch0
    do_reset();
    n = 0;
    wait_y(0, 4'b0001, n);
    chk("lat_ch0", 32'(n), 32'(45 + SYNC_ADD));
    chk("lat_other", 32'(y[3:1]), 32'd0);

    // glitch on an accepted high level is absorbed
    do_reset();
    for (int c = 0; c < 60; c++) cyc1(1'b1, 4'b0100);
    chk("g_rise", 32'(y[2]), 32'd1);
    n_evt = 0;
    for (int c = 0; c < 20; c++) cyc1(1'b1, 4'b0000);
    for (int c = 0; c < 40; c++) cyc1(1'b1, 4'b0100);
    chk("g_hold", 32'(y[2]), 32'd1);
    chk("g_evts", 32'(n_evt), 32'd0);

    // all channels rise together -> events on consecutive cycles
    do_reset();
    for (int c = 0; c < ALL4_PRE; c++) cyc1(1'b1, '0);
    n = 0;
    while (ev_ch.size() < 4 && n < 200) begin
      cyc1(1'b1, 4'b1111);
      if (evt_vld) begin
        ev_ch.push_back(int'(evt_ch));
        ev_cy.push_back(cyc_no);
      end
      n++;
    end
    chk("all4_n", 32'(ev_ch.size()), 32'd4);
    for (int k = 0; k < ev_ch.size(); k++) begin
      chk("all4_ch", 32'(ev_ch[k]), 32'(k));
      if (k > 0) chk("all4_gap", 32'(ev_cy[k] - ev_cy[k-1]), 32'd1);
    end

    // freeze mid-count on ch1 delays acceptance by the frozen cycles
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin cyc1(1'b1, 4'b0010); n++; end
    for (int c = 0; c < 20; c++) begin cyc1(1'b0, 4'b0010); n++; end
    chk("frz_y", 32'(y[1]), 32'd0);
    wait_y(1, 4'b0010, n);
    chk("lat_frz", 32'(n), 32'(66 + SYNC_ADD));

    // reset mid-count discards the partial count
    do_reset();
    for (int c = 0; c < 30; c++) cyc1(1'b1, 4'b0001);
    do_reset();
    n = 0;
    wait_y(0, 4'b0001, n);
    chk("lat_rst", 32'(n), 32'(45 + SYNC_ADD));

    // randomized: slow-moving levels, short glitches, sporadic en drops
    do_reset();
    cur = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 39) == 0) cur[k] = ~cur[k];
      drv = cur;
      if ($urandom_range(0, 19) == 0) drv[$urandom_range(0, N-1)] ^= 1'b1;
      cyc1($urandom_range(0, 7) != 0, drv);
      if (c == 2000) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
